// File: rtl/vga_pmod_monitor.sv
// Receive-side checker for a TinyVGA PMOD stream: measures line/frame sync
// geometry, computes a per-frame CRC-16-CCITT over pixel colour, and reports lock.
module vga_pmod_monitor #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int CNT_W           = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [7:0]       pmod,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_sync_len,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_sync_len,
    output logic [15:0]      frame_crc,
    output logic [15:0]      frame_count,
    output logic             frame_done,
    output logic             valid,
    output logic             locked
);
    typedef enum logic {ARMED, MEASURING} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [15:0] crcStep6(input logic [15:0] crcIn, input logic [5:0] data);
        logic [15:0] c;
        logic        fb;
        c = crcIn;
        for (int i = 5; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic               hsPrev_q, hsPrev_d, vsPrev_q, vsPrev_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d, hw_q, hw_d, vcnt_q, vcnt_d, vw_q, vw_d;
    logic [15:0]        crc_q, crc_d;
    logic [CNT_W-1:0]   hTotal_q, hTotal_d, hSyncLen_q, hSyncLen_d;
    logic [CNT_W-1:0]   vTotal_q, vTotal_d, vSyncLen_q, vSyncLen_d;
    logic [15:0]        frameCrc_q, frameCrc_d, frameCount_q, frameCount_d;
    logic               frameDone_q, frameDone_d, valid_q, valid_d, locked_q, locked_d;
    logic [4*CNT_W-1:0] snap_q, snap_d, geomNow;

    logic       hsNow, vsNow, hsLead, hsTrail, vsLead, vsTrail, measuring;
    logic [5:0] pixel;

    // Sync state is kept as "asserted" flags so polarity only matters here.
    assign hsNow     = SYNC_ACTIVE_LOW ? ~pmod[7] : pmod[7];
    assign vsNow     = SYNC_ACTIVE_LOW ? ~pmod[3] : pmod[3];
    assign hsLead    = hsNow & ~hsPrev_q;
    assign hsTrail   = ~hsNow & hsPrev_q;
    assign vsLead    = vsNow & ~vsPrev_q;
    assign vsTrail   = ~vsNow & vsPrev_q;
    assign measuring = (state_q == MEASURING);
    assign pixel     = {pmod[0], pmod[4], pmod[1], pmod[5], pmod[2], pmod[6]};

    always_comb begin
        state_d      = state_q;
        hsPrev_d     = hsPrev_q;
        vsPrev_d     = vsPrev_q;
        hcnt_d       = hcnt_q;
        hw_d         = hw_q;
        vcnt_d       = vcnt_q;
        vw_d         = vw_q;
        crc_d        = crc_q;
        hTotal_d     = hTotal_q;
        hSyncLen_d   = hSyncLen_q;
        vTotal_d     = vTotal_q;
        vSyncLen_d   = vSyncLen_q;
        frameCrc_d   = frameCrc_q;
        frameCount_d = frameCount_q;
        frameDone_d  = 1'b0;
        valid_d      = valid_q;
        locked_d     = locked_q;
        snap_d       = snap_q;
        geomNow      = '0;

        if (pix_en) begin
            hsPrev_d = hsNow;
            vsPrev_d = vsNow;

            if (hsLead) begin
                hcnt_d = CNT_ONE;
                hw_d   = CNT_ONE;
                if (measuring) hTotal_d = hcnt_q;
                if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 1'b1;
                if (vsNow && vw_q != CNT_MAX) vw_d = vw_q + 1'b1;
            end else begin
                if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 1'b1;
                if (hsNow && hw_q != CNT_MAX) hw_d = hw_q + 1'b1;
            end

            if (hsTrail && measuring) hSyncLen_d = hw_q;
            if (vsTrail && measuring) vSyncLen_d = vw_q;
            if (!hsNow && !vsNow) crc_d = crcStep6(crc_q, pixel);

            // A coincident hsync edge is counted into the frame that is ending.
            if (vsLead) begin
                vcnt_d = '0;
                vw_d   = hsLead ? CNT_ONE : '0;
                crc_d  = 16'hFFFF;
                if (!measuring) begin
                    state_d = MEASURING;
                    snap_d  = '0;
                    if (!hsLead) begin
                        hcnt_d = '0;
                        hw_d   = '0;
                    end
                end else begin
                    vTotal_d     = (hsLead && vcnt_q != CNT_MAX) ? vcnt_q + 1'b1 : vcnt_q;
                    frameCrc_d   = crc_q;
                    frameCount_d = frameCount_q + 16'd1;
                    valid_d      = 1'b1;
                    frameDone_d  = 1'b1;
                    geomNow      = {hTotal_d, hSyncLen_d, vTotal_d, vSyncLen_d};
                    locked_d     = valid_q && (geomNow == snap_q);
                    snap_d       = geomNow;
                end
            end

            // Saturated line counter means hsync has vanished.
            if (hcnt_d == CNT_MAX) locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARMED;
            hsPrev_q     <= 1'b0;
            vsPrev_q     <= 1'b0;
            hcnt_q       <= '0;
            hw_q         <= '0;
            vcnt_q       <= '0;
            vw_q         <= '0;
            crc_q        <= 16'hFFFF;
            hTotal_q     <= '0;
            hSyncLen_q   <= '0;
            vTotal_q     <= '0;
            vSyncLen_q   <= '0;
            frameCrc_q   <= '0;
            frameCount_q <= '0;
            frameDone_q  <= 1'b0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
            snap_q       <= '0;
        end else begin
            state_q      <= state_d;
            hsPrev_q     <= hsPrev_d;
            vsPrev_q     <= vsPrev_d;
            hcnt_q       <= hcnt_d;
            hw_q         <= hw_d;
            vcnt_q       <= vcnt_d;
            vw_q         <= vw_d;
            crc_q        <= crc_d;
            hTotal_q     <= hTotal_d;
            hSyncLen_q   <= hSyncLen_d;
            vTotal_q     <= vTotal_d;
            vSyncLen_q   <= vSyncLen_d;
            frameCrc_q   <= frameCrc_d;
            frameCount_q <= frameCount_d;
            frameDone_q  <= frameDone_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
            snap_q       <= snap_d;
        end
    end

    assign h_total     = hTotal_q;
    assign h_sync_len  = hSyncLen_q;
    assign v_total     = vTotal_q;
    assign v_sync_len  = vSyncLen_q;
    assign frame_crc   = frameCrc_q;
    assign frame_count = frameCount_q;
    assign frame_done  = frameDone_q;
    assign valid       = valid_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_vga_pmod_monitor.sv
// Scoreboard bench for vga_pmod_monitor: one active-low and one active-high
// instance watch the same logical video; expected frame results are queued.
module tb_vga_pmod_monitor;
    localparam int CNT_W = 12;

    typedef struct {
        logic [CNT_W-1:0] hTotal;
        logic [CNT_W-1:0] hSyncLen;
        logic [CNT_W-1:0] vTotal;
        logic [CNT_W-1:0] vSyncLen;
        logic [15:0]      crc;
        logic [15:0]      count;
        logic             locked;
    } frameExp_t;

    logic clk = 1'b0;
    logic rst;
    logic pixEn;
    logic [7:0] pmodLow, pmodHigh;

    logic [CNT_W-1:0] lowHTotal, lowHSyncLen, lowVTotal, lowVSyncLen;
    logic [15:0]      lowCrc, lowCount;
    logic             lowDone, lowValid, lowLocked;
    logic [CNT_W-1:0] highHTotal, highHSyncLen, highVTotal, highVSyncLen;
    logic [15:0]      highCrc, highCount;
    logic             highDone, highValid, highLocked;

    frameExp_t   expQ[$];
    int          checks;
    int          errors;
    bit          armedModel;
    int          countModel;
    logic [47:0] snapModel;
    logic [47:0] pendGeom;
    logic [15:0] crcModel;
    int          lens[9] = '{40, 40, 40, 40, 44, 44, 40, 40, 40};
    bit          mods[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    // Same video for both instances: the active-high copy sees inverted sync pins.
    assign pmodHigh = pmodLow ^ 8'h88;

    vga_pmod_monitor #(.SYNC_ACTIVE_LOW(1'b1), .CNT_W(CNT_W)) dutLow (
        .clk(clk), .rst(rst), .pix_en(pixEn), .pmod(pmodLow),
        .h_total(lowHTotal), .h_sync_len(lowHSyncLen), .v_total(lowVTotal),
        .v_sync_len(lowVSyncLen), .frame_crc(lowCrc), .frame_count(lowCount),
        .frame_done(lowDone), .valid(lowValid), .locked(lowLocked)
    );

    vga_pmod_monitor #(.SYNC_ACTIVE_LOW(1'b0), .CNT_W(CNT_W)) dutHigh (
        .clk(clk), .rst(rst), .pix_en(pixEn), .pmod(pmodHigh),
        .h_total(highHTotal), .h_sync_len(highHSyncLen), .v_total(highVTotal),
        .v_sync_len(highVSyncLen), .frame_crc(highCrc), .frame_count(highCount),
        .frame_done(highDone), .valid(highValid), .locked(highLocked)
    );

    function automatic logic [15:0] crcRef(input logic [15:0] c, input logic [5:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_lowHTotal"}, 32'(lowHTotal), 0);
        checkOutput({tag, "_lowHSyncLen"}, 32'(lowHSyncLen), 0);
        checkOutput({tag, "_lowVTotal"}, 32'(lowVTotal), 0);
        checkOutput({tag, "_lowVSyncLen"}, 32'(lowVSyncLen), 0);
        checkOutput({tag, "_lowCrc"}, 32'(lowCrc), 0);
        checkOutput({tag, "_lowCount"}, 32'(lowCount), 0);
        checkOutput({tag, "_lowDone"}, 32'(lowDone), 0);
        checkOutput({tag, "_lowValid"}, 32'(lowValid), 0);
        checkOutput({tag, "_lowLocked"}, 32'(lowLocked), 0);
        checkOutput({tag, "_highHTotal"}, 32'(highHTotal), 0);
        checkOutput({tag, "_highHSyncLen"}, 32'(highHSyncLen), 0);
        checkOutput({tag, "_highVTotal"}, 32'(highVTotal), 0);
        checkOutput({tag, "_highVSyncLen"}, 32'(highVSyncLen), 0);
        checkOutput({tag, "_highCrc"}, 32'(highCrc), 0);
        checkOutput({tag, "_highCount"}, 32'(highCount), 0);
        checkOutput({tag, "_highDone"}, 32'(highDone), 0);
        checkOutput({tag, "_highValid"}, 32'(highValid), 0);
        checkOutput({tag, "_highLocked"}, 32'(highLocked), 0);
    endtask

    // One pixel sample; in toggle mode an idle cycle with junk on the bus follows.
    task automatic applyStimulus(input logic hsA, input logic vsA, input logic [5:0] color, input bit toggle);
        pmodLow = {~hsA, color[0], color[2], color[4], ~vsA, color[1], color[3], color[5]};
        pixEn   = 1'b1;
        if (!hsA && !vsA) crcModel = crcRef(crcModel, color);
        @(negedge clk);
        if (toggle) begin
            pmodLow = 8'($urandom);
            pixEn   = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pushExpected();
        frameExp_t e;
        e.hTotal   = pendGeom[47:36];
        e.hSyncLen = pendGeom[35:24];
        e.vTotal   = pendGeom[23:12];
        e.vSyncLen = pendGeom[11:0];
        e.crc      = crcModel;
        e.locked   = (countModel > 0) && (pendGeom == snapModel);
        countModel++;
        e.count    = 16'(countModel);
        snapModel  = pendGeom;
        expQ.push_back(e);
    endtask

    // Frame starts with vsync and hsync leading edges on the same sample.
    task automatic sendFrame(input int len, input int hsLen, input int lines, input int vsLines,
                             input int modLine, input int modX, input bit toggle);
        logic [5:0] color;
        if (armedModel) armedModel = 1'b0;
        else pushExpected();
        crcModel = 16'hFFFF;
        for (int l = 0; l < lines; l++) begin
            for (int x = 0; x < len; x++) begin
                color = 6'((x + l * 7) & 63);
                if (l == modLine && x == modX) color = 6'h3F;
                applyStimulus(x < hsLen, l < vsLines, color, toggle);
            end
        end
        pendGeom = {12'(len), 12'(hsLen), 12'(lines), 12'(vsLines)};
    endtask

    always @(negedge clk) begin
        if (lowDone === 1'b1 || highDone === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedFrameDone actual=%0b/%0b expected=0/0", lowDone, highDone);
            end else begin
                frameExp_t e;
                e = expQ.pop_front();
                checkOutput("lowDone", 32'(lowDone), 1);
                checkOutput("lowHTotal", 32'(lowHTotal), 32'(e.hTotal));
                checkOutput("lowHSyncLen", 32'(lowHSyncLen), 32'(e.hSyncLen));
                checkOutput("lowVTotal", 32'(lowVTotal), 32'(e.vTotal));
                checkOutput("lowVSyncLen", 32'(lowVSyncLen), 32'(e.vSyncLen));
                checkOutput("lowCrc", 32'(lowCrc), 32'(e.crc));
                checkOutput("lowCount", 32'(lowCount), 32'(e.count));
                checkOutput("lowValid", 32'(lowValid), 1);
                checkOutput("lowLocked", 32'(lowLocked), 32'(e.locked));
                checkOutput("highDone", 32'(highDone), 1);
                checkOutput("highHTotal", 32'(highHTotal), 32'(e.hTotal));
                checkOutput("highHSyncLen", 32'(highHSyncLen), 32'(e.hSyncLen));
                checkOutput("highVTotal", 32'(highVTotal), 32'(e.vTotal));
                checkOutput("highVSyncLen", 32'(highVSyncLen), 32'(e.vSyncLen));
                checkOutput("highCrc", 32'(highCrc), 32'(e.crc));
                checkOutput("highCount", 32'(highCount), 32'(e.count));
                checkOutput("highValid", 32'(highValid), 1);
                checkOutput("highLocked", 32'(highLocked), 32'(e.locked));
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        pixEn      = 1'b0;
        pmodLow    = 8'h88;
        armedModel = 1'b1;
        countModel = 0;
        snapModel  = '0;
        pendGeom   = '0;
        crcModel   = 16'hFFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkAllZero("reset");

        $display("[TB] scaled VGA frames, active-low and active-high, pix_en=1");
        for (int i = 0; i < 9; i++) begin
            sendFrame(lens[i], 6, 12, 2, mods[i] ? 5 : -1, 29, 1'b0);
        end
        checkOutput("lowLockedBeforeStall", 32'(lowLocked), 1);
        checkOutput("highLockedBeforeStall", 32'(highLocked), 1);

        $display("[TB] hsync stall until line counter saturates");
        repeat (4100) applyStimulus(1'b0, 1'b0, 6'h15, 1'b0);
        checkOutput("lowLockedAfterStall", 32'(lowLocked), 0);
        checkOutput("highLockedAfterStall", 32'(highLocked), 0);
        checkOutput("lowHTotalAfterStall", 32'(lowHTotal), 40);
        checkOutput("highHTotalAfterStall", 32'(highHTotal), 40);
        checkOutput("lowCountAfterStall", 32'(lowCount), 8);
        checkOutput("highCountAfterStall", 32'(highCount), 8);

        $display("[TB] one-cycle reset mid-frame");
        rst     = 1'b1;
        pmodLow = 8'($urandom);
        @(negedge clk);
        rst        = 1'b0;
        armedModel = 1'b1;
        countModel = 0;
        snapModel  = '0;
        checkAllZero("midReset");

        $display("[TB] tiny geometry with pix_en toggling");
        for (int i = 0; i < 4; i++) begin
            sendFrame(10, 2, 6, 1, -1, 0, 1'b1);
        end
        pixEn = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
